// File: rtl/uart_host.sv
// uart_host: host-side 8N1 UART initiator that sends one byte and checks the echoed frame.
// Define UART_HOST_TIMEOUT_EN to bound the wait for the echo start bit.
module uart_host #(
    parameter int CLK_DIV      = 434,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       mosi,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       match,
    output logic       frame_err,
    output logic       timeout
);
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_OFF, R_WAIT, R_START, R_DATA, R_STOP} rx_state_t;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    tx_state_t tx_state, tx_state_d;
    rx_state_t rx_state, rx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d, rx_cnt, rx_cnt_d;
    logic [2:0] tx_bit, tx_bit_d, rx_bit, rx_bit_d;
    logic [7:0] tx_byte, tx_byte_d, rx_shift, rx_shift_d, rx_data_d;
    logic mosi_d, busy_d, done_d, match_d, frame_err_d;
    logic s1, s2, s3, accept, tx_tick, rx_tick, tmo_hit;
    assign accept  = start && !busy;
    assign tx_tick = tx_cnt == DIV_LAST;
    assign rx_tick = rx_cnt == ((rx_state == R_START) ? HALF_LAST : DIV_LAST);
    always_comb begin
        tx_state_d  = tx_state;
        tx_cnt_d    = (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + 16'd1;
        tx_bit_d    = tx_bit;
        tx_byte_d   = tx_byte;
        rx_state_d  = rx_state;
        rx_cnt_d    = (rx_tick || rx_state == R_OFF || rx_state == R_WAIT) ? '0 : rx_cnt + 16'd1;
        rx_bit_d    = rx_bit;
        rx_shift_d  = rx_shift;
        rx_data_d   = rx_data;
        done_d      = 1'b0;
        match_d     = accept ? 1'b0 : match;
        frame_err_d = accept ? 1'b0 : frame_err;
        case (tx_state)
            T_IDLE:  if (accept) begin
                tx_state_d = T_START;
                tx_byte_d  = tx_data;
            end
            T_START: if (tx_tick) begin
                tx_state_d = T_DATA;
                tx_bit_d   = 3'd0;
            end
            T_DATA:  if (tx_tick) begin
                tx_bit_d   = tx_bit + 3'd1;
                tx_state_d = (tx_bit == 3'd7) ? T_STOP : T_DATA;
            end
            default: tx_state_d = tx_tick ? T_IDLE : T_STOP;
        endcase
        mosi_d = !(tx_state_d == T_START || (tx_state_d == T_DATA && !tx_byte_d[tx_bit_d]));
        // The slave may start echoing during our stop bit, so listen from its first cycle
        case (rx_state)
            R_OFF:   if (tx_state_d == T_STOP && tx_state != T_STOP) rx_state_d = R_WAIT;
            R_WAIT:  if (tmo_hit) begin
                rx_state_d = R_OFF;
                done_d     = 1'b1;
                match_d    = 1'b0;
            end else if (s3 && !s2) rx_state_d = R_START;
            R_START: if (rx_tick) begin
                rx_state_d = s2 ? R_WAIT : R_DATA;
                rx_bit_d   = 3'd0;
            end
            R_DATA:  if (rx_tick) begin
                rx_shift_d = {s2, rx_shift[7:1]};
                rx_bit_d   = rx_bit + 3'd1;
                rx_state_d = (rx_bit == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP:  if (rx_tick) begin
                rx_state_d  = R_OFF;
                rx_data_d   = rx_shift;
                frame_err_d = !s2;
                match_d     = s2 && rx_shift == tx_byte;
                done_d      = 1'b1;
            end
            default: rx_state_d = R_OFF;
        endcase
        busy_d = accept ? 1'b1 : (done_d ? 1'b0 : busy);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= T_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_byte   <= '0;
            rx_state  <= R_OFF;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            mosi      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            frame_err <= 1'b0;
            {s1, s2, s3} <= 3'b111;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_bit    <= tx_bit_d;
            tx_byte   <= tx_byte_d;
            rx_state  <= rx_state_d;
            rx_cnt    <= rx_cnt_d;
            rx_bit    <= rx_bit_d;
            rx_shift  <= rx_shift_d;
            rx_data   <= rx_data_d;
            mosi      <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
            match     <= match_d;
            frame_err <= frame_err_d;
            {s1, s2, s3} <= {miso, s1, s2};
        end
    end
`ifdef UART_HOST_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * CLK_DIV - 1);
    logic [31:0] tcnt;
    // Keeps counting through a rejected start so a glitch cannot stretch the window
    assign tmo_hit = rx_state == R_WAIT && tcnt >= TMO_LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= (rx_state == R_OFF) ? '0 : tcnt + 32'd1;
            timeout <= accept ? 1'b0 : (timeout || tmo_hit);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_host.sv
// tb_uart_host: randomized echo transactions against a frame-level reference model.
module tb_uart_host;
    localparam int DIV = 16;
    localparam int LAT = 3 + (19 * DIV) / 2;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, miso = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic mosi, busy, done, match, frame_err, timeout;
    logic [7:0] rx_data;
    int total = 0, bad = 0;
    uart_host #(.CLK_DIV(DIV), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .mosi(mosi), .miso(miso),
        .busy(busy), .done(done), .rx_data(rx_data), .match(match), .frame_err(frame_err),
        .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic xact(input logic [7:0] tx, input logic [7:0] echo, input logic stop_bit,
                        input bit extra_start);
        logic [9:0] hf, ef;
        int es, done_c, n_done, mosi_err, busy_err;
        hf = {1'b1, tx, 1'b0};
        ef = {stop_bit, echo, 1'b0};
        es = 144 + int'($urandom_range(0, DIV - 1));
        done_c = -1; n_done = 0; mosi_err = 0; busy_err = 0;
        tx_data = tx;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("clr_match", int'(match), 0);
        check("clr_ferr", int'(frame_err), 0);
        check("clr_tmo", int'(timeout), 0);
        for (int c = 0; c < es + 175; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (mosi !== ((c < 160) ? hf[c / DIV] : 1'b1)) mosi_err++;
            if (done === 1'b1) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (busy !== (done_c < 0)) busy_err++;
            start = extra_start && c == 50;
            if (extra_start && c == 50) tx_data = 8'hFF;
            miso = (c >= es && c < es + 160) ? ef[(c - es) / DIV] : 1'b1;
        end
        check("mosi_frame", mosi_err, 0);
        check("busy_window", busy_err, 0);
        check("done_lat", done_c, es + LAT);
        check("done_cnt", n_done, 1);
        check("rx_data", int'(rx_data), int'(echo));
        check("match", int'(match), int'(stop_bit && echo == tx));
        check("frame_err", int'(frame_err), int'(!stop_bit));
    endtask
`ifdef UART_HOST_TIMEOUT_EN
    task automatic tmo_xact(input logic [7:0] tx);
        int done_c = -1, n_done = 0;
        tx_data = tx;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 260; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            miso = !(c >= 164 && c < 167);
        end
        check("tmo_lat", done_c, 144 + 4 * DIV);
        check("tmo_cnt", n_done, 1);
        check("tmo_flag", int'(timeout), 1);
        check("tmo_match", int'(match), 0);
        check("tmo_busy", int'(busy), 0);
    endtask
`endif
    initial begin
        logic [7:0] a, e;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mosi", int'(mosi), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rx", int'(rx_data), 0);
        check("rst_match", int'(match), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_tmo", int'(timeout), 0);
        @(negedge clk) rst_n = 1'b1;
        xact(8'hA5, 8'hA5, 1'b1, 1'b0);
        xact(8'hA5, 8'h5A, 1'b1, 1'b0);
        xact(8'hA5, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            e = ($urandom_range(0, 1) == 0) ? a : 8'($urandom);
            xact(a, e, $urandom_range(0, 3) != 0, 1'b0);
        end
        xact(8'h81, 8'h81, 1'b1, 1'b1);
        tx_data = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_mosi", int'(mosi), 1);
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        check("mid_rx", int'(rx_data), 0);
        check("mid_match", int'(match), 0);
        check("mid_ferr", int'(frame_err), 0);
        check("mid_tmo", int'(timeout), 0);
        @(negedge clk) rst_n = 1'b1;
        xact(8'hC3, 8'hC3, 1'b1, 1'b0);
`ifdef UART_HOST_TIMEOUT_EN
        tmo_xact(8'h77);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
